// File: rtl/program_loader.sv
// Framed program-image loader: SYNC, 16-bit little-endian length, payload, 8-bit additive checksum.
// Holds the CPU in reset while writing payload bytes to memory, then releases it once the image verifies.
module program_loader #(
   parameter int          MEM_BYTES = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic [31:0] prog_addr,
   output logic [7:0]  prog_byte,
   output logic        prog_wr_en,
   output logic        start_program,
   output logic        cpu_reset,
   output logic        load_error,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE} state_t;

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   state_t      state_q;
   logic [15:0] len_q, idx_q;
   logic [7:0]  csum_q, byte_q;
   logic [31:0] addr_q;
   logic        wr_q, start_q, cpurst_q, err_q, busy_q, rdy_q;

   logic        acc;
   logic [15:0] len_d;

   assign acc   = rx_valid && rdy_q;
   assign len_d = {rx_data, len_q[7:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         len_q    <= '0;
         idx_q    <= '0;
         csum_q   <= '0;
         addr_q   <= '0;
         byte_q   <= '0;
         wr_q     <= 1'b0;
         start_q  <= 1'b0;
         cpurst_q <= 1'b1;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         wr_q <= 1'b0;
         if (acc) begin
            case (state_q)
               IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q <= LEN_LO;
                     err_q   <= 1'b0;
                     csum_q  <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               LEN_LO: begin
                  len_q[7:0] <= rx_data;
                  state_q    <= LEN_HI;
               end
               LEN_HI: begin
                  len_q[15:8] <= rx_data;
                  if (len_d == 16'd0 || {16'd0, len_d} > MEM_LIMIT) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     idx_q   <= '0;
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  addr_q <= BASE_ADDR + {16'd0, idx_q};
                  byte_q <= rx_data;
                  wr_q   <= 1'b1;
                  csum_q <= csum_q + rx_data;
                  idx_q  <= idx_q + 16'd1;
                  if (idx_q == len_q - 16'd1) state_q <= CHECK;
               end
               CHECK: begin
                  busy_q <= 1'b0;
                  if (rx_data == csum_q) begin
                     state_q  <= DONE;
                     start_q  <= 1'b1;
                     cpurst_q <= 1'b0;
                     rdy_q    <= 1'b0;
                  end else begin
                     // Partial image stays in memory; only the flag records the rejection.
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready      = rdy_q;
   assign prog_addr     = addr_q;
   assign prog_byte     = byte_q;
   assign prog_wr_en    = wr_q;
   assign start_program = start_q;
   assign cpu_reset     = cpurst_q;
   assign load_error    = err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: frames are built at frame level and the
// expected memory writes / release status come from the payload and its checksum.
module tb_program_loader;

   logic        clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready, prog_wr_en, start_program, cpu_reset, load_error, busy;
   logic [31:0] prog_addr;
   logic [7:0]  prog_byte;

   program_loader dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .prog_addr(prog_addr), .prog_byte(prog_byte), .prog_wr_en(prog_wr_en),
      .start_program(start_program), .cpu_reset(cpu_reset), .load_error(load_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [39:0] obs[$];
   int          late_strobes = 0;
   logic [7:0]  pay[$];

   // status = {start_program, cpu_reset, load_error, busy, rx_ready}
   localparam logic [4:0] ST_DONE = 5'b10000, ST_ERR = 5'b01101, ST_IDLE = 5'b01001;
   wire [4:0] status = {start_program, cpu_reset, load_error, busy, rx_ready};

   always @(negedge clk) begin
      if (prog_wr_en) begin
         obs.push_back({prog_addr, prog_byte});
         if (start_program) late_strobes++;
      end
   end

   function automatic logic [7:0] sum8();
      logic [7:0] s = 8'h00;
      foreach (pay[i]) s = s + pay[i];
      return s;
   endfunction

   // Number of wrong/missing/extra writes since obs index 'first'; payload i goes to address i.
   function automatic int write_errs(int first, bit expect_writes);
      int n = expect_writes ? pay.size() : 0;
      int bad = 0;
      int got = obs.size() - first;
      if (got != n) bad = 1000 + got;
      else for (int i = 0; i < n; i++)
         if (obs[first+i] !== {32'(i), pay[i]}) bad++;
      return bad;
   endfunction

   function automatic logic [7:0] rnd_non_sync();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      return b;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int lo, input int hi);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(hi, lo)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] len, input logic [7:0] ck, input bit tail,
                             input int lo, input int hi);
      send_byte(8'hA5, lo, hi);
      send_byte(len[7:0], lo, hi);
      send_byte(len[15:8], lo, hi);
      if (tail) begin
         foreach (pay[i]) send_byte(pay[i], lo, hi);
         send_byte(ck, lo, hi);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({prog_addr, prog_byte, prog_wr_en} !== 41'd0) begin
         errors++; $display("FAIL reset_mem_if got %h need 0", {prog_addr, prog_byte, prog_wr_en});
      end
      checks++;
      if (status !== ST_IDLE) begin errors++; $display("FAIL reset_status got %b need %b", status, ST_IDLE); end
   endtask

   task automatic test_nominal();
      int first = obs.size();
      int we;
      pay = '{8'h11, 8'h22, 8'h33};
      send_frame(16'd3, 8'h66, 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0) begin errors++; $display("FAIL nominal_writes got %0d bad (count %0d) need 0", we, obs.size()-first); end
      checks++;
      if (status !== ST_DONE) begin errors++; $display("FAIL nominal_status got %b need %b", status, ST_DONE); end
      // DONE is absorbing: an offered byte is refused and produces no write.
      first = obs.size();
      send_byte(8'hA5, 2, 2);
      checks++;
      if (obs.size() != first || status !== ST_DONE) begin
         errors++; $display("FAIL done_absorb got writes %0d status %b need 0 %b", obs.size()-first, status, ST_DONE);
      end
      do_reset();
   endtask

   task automatic test_bad_checksum();
      int first = obs.size();
      int we;
      pay = '{8'h01, 8'h02};
      send_frame(16'd2, 8'h04, 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0) begin errors++; $display("FAIL badck_writes got %0d bad need 0", we); end
      checks++;
      if (status !== ST_ERR) begin errors++; $display("FAIL badck_status got %b need %b", status, ST_ERR); end
      first = obs.size();
      pay = '{8'h7F};
      send_frame(16'd1, 8'h7F, 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0 || status !== ST_DONE) begin
         errors++; $display("FAIL badck_recover got bad %0d status %b need 0 %b", we, status, ST_DONE);
      end
      do_reset();
   endtask

   task automatic test_noise_and_length();
      int first = obs.size();
      int we;
      send_byte(8'h00, 0, 0); send_byte(8'hFF, 0, 0); send_byte(8'h5A, 0, 0);
      checks++;
      if (obs.size() != first || status !== ST_IDLE) begin
         errors++; $display("FAIL noise_ignored got writes %0d status %b need 0 %b", obs.size()-first, status, ST_IDLE);
      end
      pay = '{8'h09};
      send_frame(16'd1, 8'h09, 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0 || status !== ST_DONE) begin
         errors++; $display("FAIL noise_frame got bad %0d status %b need 0 %b", we, status, ST_DONE);
      end
      do_reset();
      pay.delete();
      first = obs.size();
      send_frame(16'd0, 8'h00, 1'b0, 0, 0);
      checks++;
      if (status !== ST_ERR || obs.size() != first) begin
         errors++; $display("FAIL len_zero got status %b writes %0d need %b 0", status, obs.size()-first, ST_ERR);
      end
      send_frame(16'd1025, 8'h00, 1'b0, 0, 1);
      checks++;
      if (status !== ST_ERR || obs.size() != first) begin
         errors++; $display("FAIL len_over got status %b writes %0d need %b 0", status, obs.size()-first, ST_ERR);
      end
   endtask

   task automatic test_gaps();
      int first = obs.size();
      int we;
      pay = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(16'd4, 8'h0A, 1'b1, 1, 3);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0 || status !== ST_DONE) begin
         errors++; $display("FAIL gaps_frame got bad %0d status %b need 0 %b", we, status, ST_DONE);
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         int first, we, len;
         bit good;
         logic [7:0] ck;
         repeat ($urandom_range(3, 0)) send_byte(rnd_non_sync(), 0, 1);
         first = obs.size();
         len   = $urandom_range(40, 1);
         pay.delete();
         for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
         good = 1'($urandom_range(1, 0));
         ck   = good ? sum8() : sum8() + 8'($urandom_range(255, 1));
         send_frame(16'(len), ck, 1'b1, 0, 2);
         we = write_errs(first, 1'b1);
         checks++;
         if (we !== 0 || status !== (good ? ST_DONE : ST_ERR)) begin
            errors++; $display("FAIL random_frame%0d got bad %0d status %b need 0 %b", f, we, status, good ? ST_DONE : ST_ERR);
         end
         if (good) do_reset();
      end
   endtask

   task automatic test_full();
      int first = obs.size();
      int we;
      pay.delete();
      for (int i = 0; i < 1024; i++) pay.push_back(8'($urandom));
      send_frame(16'd1024, sum8(), 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0 || obs[obs.size()-1][39:8] !== 32'h3FF) begin
         errors++; $display("FAIL full_writes got bad %0d last addr %h need 0 3ff", we, obs[obs.size()-1][39:8]);
      end
      checks++;
      if (status !== ST_DONE) begin errors++; $display("FAIL full_status got %b need %b", status, ST_DONE); end
      do_reset();
   endtask

   task automatic test_reset_mid_data();
      int first = obs.size();
      int we;
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(rnd_non_sync());
      send_byte(8'hA5, 0, 0); send_byte(8'h04, 0, 0); send_byte(8'h00, 0, 0);
      send_byte(pay[0], 0, 0); send_byte(pay[1], 0, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({prog_wr_en, busy, cpu_reset, load_error} !== 4'b0010) begin
         errors++; $display("FAIL midreset_out got %b need 0010", {prog_wr_en, busy, cpu_reset, load_error});
      end
      first = obs.size();
      send_byte(pay[2], 0, 0); send_byte(pay[3], 0, 0); send_byte(sum8(), 0, 0);
      checks++;
      if (obs.size() != first || status !== ST_IDLE) begin
         errors++; $display("FAIL midreset_ignore got writes %0d status %b need 0 %b", obs.size()-first, status, ST_IDLE);
      end
      send_frame(16'd4, sum8(), 1'b1, 0, 0);
      we = write_errs(first, 1'b1);
      checks++;
      if (we !== 0 || status !== ST_DONE) begin
         errors++; $display("FAIL midreset_reload got bad %0d status %b need 0 %b", we, status, ST_DONE);
      end
      do_reset();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_noise_and_length();
      test_gaps();
      test_random();
      test_full();
      test_reset_mid_data();
      checks++;
      if (late_strobes !== 0) begin errors++; $display("FAIL strobe_after_start got %0d need 0", late_strobes); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
